// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers pixel coordinates, active video and lock from VGA sync edges.
// Define VGA_RX_CRC_EN to build the per-frame CRC-16 of active pixels on FrameCrc.
module vga_sync_rx #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_BACK      = 144,
    parameter int V_BACK      = 35,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        CLK,
    input  logic        nReset,
    input  logic        HSync,
    input  logic        VSync,
    input  logic [2:0]  Red,
    input  logic [2:0]  Green,
    input  logic [1:0]  Blue,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        De,
    output logic [7:0]  Pix,
    output logic        Lock,
    output logic        FrameStart,
    output logic        SyncErr,
    output logic [15:0] FrameCrc
);
    localparam logic [1:0]  ST_SEARCH  = 2'd0;
    localparam logic [1:0]  ST_MEASURE = 2'd1;
    localparam logic [1:0]  ST_LOCKED  = 2'd2;
    localparam logic [10:0] HCNT_MAX   = 11'(2 * H_TOTAL);
    localparam logic [11:0] H_LEN      = 12'(H_TOTAL);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_LO       = 11'(H_BACK);
    localparam logic [10:0] H_HI       = 11'(H_BACK + H_ACTIVE);
    localparam logic [9:0]  V_LO       = 10'(V_BACK);
    localparam logic [9:0]  V_HI       = 10'(V_BACK + V_ACTIVE);
    localparam logic [7:0]  GOOD_LOCK  = 8'(LOCK_FRAMES);

    logic [2:0]  hs_q, vs_q;
    logic [7:0]  pix1_q, pix2_q;
    logic        hs_fall_s, vs_fall_s;
    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic [1:0]  state_q, state_d;
    logic [7:0]  good_q, good_d;
    logic        skip_q, skip_d, lock_q, lock_d;
    logic        fs_q, fs_d, err_q, err_d;
    logic        line_err_s, frame_err_s, timeout_s, viol_s, act_s;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic        de_q;
    logic [7:0]  pix_q;

    // Sync synchronizer plus history flop, and pixel delay matching the sync path
    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            hs_q   <= 3'b111;
            vs_q   <= 3'b111;
            pix1_q <= 8'd0;
            pix2_q <= 8'd0;
        end else begin
            hs_q   <= {hs_q[1:0], HSync};
            vs_q   <= {vs_q[1:0], VSync};
            pix1_q <= {Red, Green, Blue};
            pix2_q <= pix1_q;
        end
    end

    assign hs_fall_s = hs_q[2] & ~hs_q[1];
    assign vs_fall_s = vs_q[2] & ~vs_q[1];

    // Next-state counters; hcnt_d is the column of the pixel now leaving the delay line
    always_comb begin
        if (hs_fall_s) begin
            hcnt_d = 11'd0;
        end else if (hcnt_q == HCNT_MAX) begin
            hcnt_d = hcnt_q;
        end else begin
            hcnt_d = hcnt_q + 11'd1;
        end
        if (vs_fall_s) begin
            vcnt_d = 10'd0;
        end else if (hs_fall_s) begin
            vcnt_d = vcnt_q + 10'd1;
        end else begin
            vcnt_d = vcnt_q;
        end
    end

    assign line_err_s  = hs_fall_s & ~skip_q & (({1'b0, hcnt_q} + 12'd1) != H_LEN);
    assign frame_err_s = vs_fall_s & (vcnt_q != V_LAST);
    assign timeout_s   = (hcnt_d == HCNT_MAX);
    assign viol_s      = line_err_s | frame_err_s | timeout_s;

    // Lock FSM: a violation always beats a coincident VSync edge
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        skip_d  = skip_q;
        lock_d  = lock_q;
        fs_d    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                lock_d = 1'b0;
                if (vs_fall_s) begin
                    state_d = ST_MEASURE;
                    good_d  = 8'd0;
                    skip_d  = 1'b1;
                end else begin
                    state_d = ST_SEARCH;
                end
            end
            ST_MEASURE: begin
                if (viol_s) begin
                    err_d   = 1'b1;
                    state_d = ST_SEARCH;
                end else begin
                    skip_d = skip_q & ~hs_fall_s;
                    if (vs_fall_s && ((good_q + 8'd1) == GOOD_LOCK)) begin
                        state_d = ST_LOCKED;
                        lock_d  = 1'b1;
                    end else if (vs_fall_s) begin
                        good_d = good_q + 8'd1;
                    end else begin
                        good_d = good_q;
                    end
                end
            end
            ST_LOCKED: begin
                if (viol_s) begin
                    err_d   = 1'b1;
                    lock_d  = 1'b0;
                    state_d = ST_SEARCH;
                end else begin
                    fs_d = vs_fall_s;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                lock_d  = 1'b0;
            end
        endcase
    end

    assign act_s = lock_d & (hcnt_d >= H_LO) & (hcnt_d < H_HI) & (vcnt_d >= V_LO) & (vcnt_d < V_HI);

    // Coordinates are zero outside the gated active area
    always_comb begin
        if (act_s) begin
            x_d = 10'(hcnt_d - H_LO);
            y_d = vcnt_d - V_LO;
        end else begin
            x_d = 10'd0;
            y_d = 10'd0;
        end
    end

    // Timing state and registered outputs
    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            hcnt_q  <= 11'd0;
            vcnt_q  <= 10'd0;
            state_q <= ST_SEARCH;
            good_q  <= 8'd0;
            skip_q  <= 1'b0;
            lock_q  <= 1'b0;
            fs_q    <= 1'b0;
            err_q   <= 1'b0;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            de_q    <= 1'b0;
            pix_q   <= 8'd0;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            state_q <= state_d;
            good_q  <= good_d;
            skip_q  <= skip_d;
            lock_q  <= lock_d;
            fs_q    <= fs_d;
            err_q   <= err_d;
            x_q     <= x_d;
            y_q     <= y_d;
            de_q    <= act_s;
            pix_q   <= pix2_q;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign De         = de_q;
    assign Pix        = pix_q;
    assign Lock       = lock_q;
    assign FrameStart = fs_q;
    assign SyncErr    = err_q;

`ifdef VGA_RX_CRC_EN
    function automatic logic [15:0] crc16_step(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    logic [15:0] crc_q, crc_d, fcrc_q, fcrc_d;

    // Running CRC restarts on every VSync edge; the result is published only on locked edges
    always_comb begin
        if (vs_fall_s) begin
            crc_d = 16'hFFFF;
        end else if (act_s) begin
            crc_d = crc16_step(crc_q, pix2_q);
        end else begin
            crc_d = crc_q;
        end
        if (fs_d) begin
            fcrc_d = crc_q;
        end else begin
            fcrc_d = fcrc_q;
        end
    end

    // CRC registers
    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            crc_q  <= 16'hFFFF;
            fcrc_q <= 16'd0;
        end else begin
            crc_q  <= crc_d;
            fcrc_q <= fcrc_d;
        end
    end

    assign FrameCrc = fcrc_q;
`else
    assign FrameCrc = 16'd0;
`endif

endmodule

// File: doc/vga_sync_rx.md
# vga_sync_rx

Receive-side VGA timing recovery block. It takes an HSync/VSync/RGB stream, such as the one our `vga_sync`-driven pixel generator drives, and re-derives pixel coordinates, an active-video flag and a lock indication from the sync edges alone. It sits at the input of a capture or loopback checker path. It also measures line and frame lengths and flags any deviation from the configured mode.

## Interface
Parameters:
- H_TOTAL, 800: clocks per line
- V_TOTAL, 525: lines per frame
- H_BACK, 144: clocks from HSync falling edge to first active pixel (sync + back porch)
- V_BACK, 35: lines from VSync falling edge to first active line
- H_ACTIVE, 640: active pixels per line
- V_ACTIVE, 480: active lines per frame
- LOCK_FRAMES, 2: consecutive good frames required for lock

Ports:
- CLK  in  1  pixel clock, same frequency as the source pixel clock
- nReset  in  1  asynchronous, active-low reset
- HSync  in  1  horizontal sync, active low, asynchronous to CLK phase
- VSync  in  1  vertical sync, active low
- Red  in  3  pixel red
- Green  in  3  pixel green
- Blue  in  2  pixel blue
- x  out  10  recovered column, valid when De=1
- y  out  10  recovered row, valid when De=1
- De  out  1  active-video flag, gated by Lock
- Pix  out  8  {Red,Green,Blue} aligned with x/y/De
- Lock  out  1  timing locked
- FrameStart  out  1  one-cycle pulse on each VSync falling edge while locked
- SyncErr  out  1  one-cycle pulse on any timing violation
- FrameCrc  out  16  CRC of previous frame's active pixels (see Configuration)

## Operation
- HSync and VSync pass through a 2-flop synchronizer plus 1 history flop. All three flops reset to 1 (idle), so no edge is seen out of reset.
- The pixel bus is delayed by 2 flops so it stays aligned with the synchronized syncs.
- hcnt (11 bit):
  - Cleared on the detected HSync falling edge, otherwise increments.
  - Saturates at 2*H_TOTAL.
  - The pixel input presented k cycles after the HSync falling edge is paired with hcnt=k.
- vcnt (10 bit):
  - Cleared on the VSync falling edge.
  - Increments on each HSync falling edge otherwise.
- Line check: at each HSync edge, hcnt+1 must equal H_TOTAL. This check is skipped for the first edge after leaving SEARCH.
- Frame check: at a VSync edge, vcnt must equal V_TOTAL-1 (counting the HS edges of one frame).
- Timeout: hcnt reaching 2*H_TOTAL counts as a violation.
- FSM states:
  - SEARCH (reset state): wait for a VSync edge, then go to MEASURE with good=0.
  - MEASURE: a line/frame violation or timeout pulses SyncErr and returns to SEARCH. Each clean VSync edge increments good. When good reaches LOCK_FRAMES, go to LOCKED and set Lock.
  - LOCKED: any violation pulses SyncErr, clears Lock and goes to SEARCH. Each VSync edge pulses FrameStart.
- Active-area flag: act = Lock & (H_BACK ≤ hcnt < H_BACK+H_ACTIVE) & (V_BACK ≤ vcnt < V_BACK+V_ACTIVE).
- Coordinates: x = hcnt−H_BACK and y = vcnt−V_BACK, truncated to 10 bits. Both are forced to 0 when act=0.
- If a violation and a VSync edge occur in the same cycle, the violation wins: no FrameStart, no good increment.

## Timing
- Reset values: x=0, y=0, De=0, Pix=0, Lock=0, FrameStart=0, SyncErr=0, FrameCrc=0. FSM is in SEARCH.
- Pixel latency is fixed at 3 CLK cycles. The input pixel at cycle t appears on Pix/x/y/De at t+3.
- FrameStart, SyncErr and Lock transitions appear 3 cycles after the causing input edge.
- Lock rises in the same cycle as the FrameStart-equivalent edge that completes the LOCK_FRAMES-th good frame.
- Lock falls in the same cycle that SyncErr pulses.
- When nReset is asserted mid-frame, all state clears immediately. Relock requires a VSync edge plus LOCK_FRAMES good frames.

## Configuration
- VGA_RX_CRC_EN defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first, 8 bits per De cycle) runs over Pix.
  - The CRC is latched into FrameCrc and re-initialised at each VSync edge while locked.
  - FrameCrc holds its value when not locked.
- VGA_RX_CRC_EN undefined: no CRC logic is built, and FrameCrc is tied to 0.

## Test plan
- Nominal lock: 800×525 stimulus, 3 frames → Lock=1 exactly at the end of frame 2 (3 cycles after its VSync edge); frame 3 has exactly 640×480 De cycles.
- Coordinates: Pix input = x[7:0]^y[7:0] from the model → every De cycle has Pix==x[7:0]^y[7:0]; the first De is at x=0,y=0, the last at x=639,y=479; latency is 3.
- Bad line: while locked, one line of 801 clocks → SyncErr pulses once, Lock goes to 0 in the same cycle, De stays 0 until relock 2 frames later.
- HSync loss: HSync held high for 1700 cycles → SyncErr at hcnt=1600, state SEARCH, Lock=0.
- Reset mid-frame: nReset low at line 200 → all outputs 0 within the same cycle; after release, Lock returns after 1 partial + 2 full frames.
- CRC (with VGA_RX_CRC_EN): two identical frames → equal FrameCrc matching the model; flipping one pixel at (10,20) → FrameCrc changes; without the macro FrameCrc=0.
